regfile_writeback_arbiter: RTL and testbench
============================================

// Module: regfile_writeback_arbiter
// PURPOSE
//  Writeback stage directly upstream of regfile32x64: collects results from the ALU and the
//  data-memory unit, buffers each source in a small FIFO and serialises them onto the single
//  regfile write port (write/wrAddr/wrData). Also exports a per-register pending-write
//  vector for the issue/hazard logic.
// PARAMETERS
//  AW        5    register address width (32 registers)
//  DW        64   data width
//  DEPTH     2    entries per source FIFO (power of 2, >=2)
//  DROP_XZR  0    1: writes to register 31 are accepted and discarded; 0: stored as normal
// PORTS
//  clk       in   1     clock; all logic on rising edge
//  reset     in   1     asynchronous, active-high reset
//  aluValid  in   1     ALU result valid
//  aluReady  out  1     ALU FIFO can accept
//  aluAddr   in   AW    ALU destination register
//  aluData   in   DW    ALU result
//  memValid  in   1     memory load result valid
//  memReady  out  1     memory FIFO can accept
//  memAddr   in   AW    memory destination register
//  memData   in   DW    memory load data
//  write     out  1     regfile write enable (registered)
//  wrAddr    out  AW    regfile write address (registered)
//  wrData    out  DW    regfile write data (registered)
//  busy      out  32    busy[r]=1 while a write to r is buffered or on the write port
//  conflict  out  1     one-cycle pulse: accepted write targets a reg busy from the other source
// BEHAVIOUR
//  - Reset (async, any time incl. mid-operation): both FIFOs flushed, write=0, wrAddr=0,
//    wrData=0, busy=0, conflict=0, RR pointer=ALU; aluReady=memReady=0 while reset is high.
//  - Handshake: transfer when xValid&&xReady at a rising edge. xReady = (count_x < DEPTH);
//    no pass-through when full, even if that FIFO pops the same cycle. Data/addr must be
//    stable only in the transfer cycle. Both sources may transfer in the same cycle.
//  - Arbitration (combinational on FIFO heads, each cycle): one head non-empty -> grant it;
//    both non-empty -> grant RR-pointer source, pointer then flips to the other source.
//    Pointer changes only on a contested grant. Grant pops head at next edge.
//  - Output register: on grant, next edge loads write=1, wrAddr/wrData=head; no grant ->
//    write=0, wrAddr/wrData hold last value. Latency: transfer at edge k -> write=1 in the
//    cycle after edge k+1 (2 cycles) when uncontested. Throughput 1 write/cycle.
//  - Order preserved within a source; no ordering between sources. Issue logic must not
//    have writes to the same reg outstanding on both sources; violation -> conflict pulse
//    (cycle after the offending transfer); both writes still performed, arbitration order.
//  - busy[r] set at the transfer edge; cleared at the edge ending the write=1 cycle for
//    that entry, unless another buffered entry still targets r (count per reg, not flag).
//  - DROP_XZR=1 and addr==31: handshake completes, entry not enqueued, busy[31] untouched,
//    no conflict check.
//  - Width rules: addr/data passed unmodified; no arithmetic beyond FIFO pointers/counts
//    (pointers wrap modulo DEPTH, count is clog2(DEPTH)+1 bits).
// STRUCTURE
//  - Shared include wb_defs.vh: REG_XZR=5'd31, SRC_ALU=1'b0, SRC_MEM=1'b1, default AW/DW.
//  - Sub-module wb_fifo (DEPTH x (AW+DW), push/pop/full/empty/count, async reset),
//    instantiated once per source; arbiter, output register and busy counters in top.
// TESTING
//  1 reset: reset=1 for 5 cycles with aluValid=1 -> aluReady=0, write=0, busy=0; release
//    -> aluReady=1 next cycle.
//  2 single ALU write addr 8, data AAAA_AAAA_AAAA_AAAA -> write=1 exactly 2 cycles after
//    transfer with wrAddr=8; busy[8]=1 from transfer until after that cycle; regfile rdDataA
//    at addr 8 returns AAAA... afterwards.
//  3 contention: ALU(15,CCCC..) and MEM(31,F0F0..) every cycle for 6 cycles -> writes
//    alternate ALU,MEM,ALU,...; both readys drop when FIFOs fill; no transfer lost/duplicated.
//  4 backpressure: MEM pushes 3 writes while ALU floods -> memReady=0 after DEPTH entries,
//    memory writes appear in push order.
//  5 conflict: ALU write reg 0 pending, MEM write reg 0 -> conflict=1 one cycle; both writes
//    reach wrAddr=0, busy[0] clears only after second.
//  6 reset mid-stream with 3 entries buffered -> write=0 immediately, no buffered entry ever
//    written after release; DROP_XZR=1 build: write to 31 -> write stays 0, busy[31]=0.

Source files
------------

// File: rtl/regfile_writeback_arbiter_pkg.sv
// Shared constants and types for the regfile writeback arbiter.
// Contents: default address/data widths, the zero-register index and the
// source identifiers used by the round-robin pointer and the write-port tag.
package regfile_writeback_arbiter_pkg;

  localparam int unsigned WB_AW = 5;
  localparam int unsigned WB_DW = 64;

  // Architectural zero register; optionally discarded at the handshake.
  localparam logic [4:0] REG_XZR = 5'd31;

  // Result source; also the encoding of the round-robin pointer.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/regfile_writeback_arbiter_fifo.sv
// Small per-source result FIFO (DEPTH entries of W bits).
// Ports:
//   clk, reset     clock, asynchronous active-high reset (flushes the FIFO)
//   push_i         enqueue push_data_i at the rising edge (caller guarantees not full)
//   push_data_i    entry to enqueue
//   pop_i          dequeue the head at the rising edge (caller guarantees not empty)
//   head_c_o       current head entry (combinational read of storage)
//   empty_o        no entries buffered
//   count_o        number of entries buffered
module regfile_writeback_arbiter_fifo #(
  parameter int unsigned W     = 69,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [W-1:0]             push_data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_c_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push_i) - CW'(pop_i);
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_c_o = mem_q[rd_ptr_q];
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Writeback arbiter in front of the register file: buffers ALU and memory
// results in one FIFO each, serialises them round-robin onto the single
// registered write port, and tracks per-register pending writes.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   aluValid/aluReady/aluAddr/aluData  ALU result handshake
//   memValid/memReady/memAddr/memData  memory load result handshake
//   write/wrAddr/wrData             registered regfile write port
//   busy                            per-register pending-write vector (registered)
//   conflict                        one-cycle pulse: same register outstanding on both sources
module regfile_writeback_arbiter
  import regfile_writeback_arbiter_pkg::*;
#(
  parameter int unsigned AW       = WB_AW,
  parameter int unsigned DW       = WB_DW,
  parameter int unsigned DEPTH    = 2,
  parameter bit          DROP_XZR = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 aluValid,
  output logic                 aluReady,
  input  logic [AW-1:0]        aluAddr,
  input  logic [DW-1:0]        aluData,
  input  logic                 memValid,
  output logic                 memReady,
  input  logic [AW-1:0]        memAddr,
  input  logic [DW-1:0]        memData,
  output logic                 write,
  output logic [AW-1:0]        wrAddr,
  output logic [DW-1:0]        wrData,
  output logic [(1<<AW)-1:0]   busy,
  output logic                 conflict
);

  localparam int unsigned NREG = 1 << AW;
  localparam int unsigned EW   = AW + DW;
  localparam int unsigned FCW  = $clog2(DEPTH) + 1;
  // Per source and register: up to DEPTH buffered plus one on the write port.
  localparam int unsigned CW   = $clog2(DEPTH + 2);

  logic [FCW-1:0] alu_count, mem_count;
  logic           alu_empty, mem_empty;
  logic [EW-1:0]  alu_head, mem_head;
  logic           alu_push, mem_push;
  logic           alu_grant, mem_grant;
  wb_src_e        rr_q, rr_d;
  wb_src_e        wr_src_q;
  logic           conflict_d;

  logic [NREG-1:0][CW-1:0] alu_cnt_q, alu_cnt_d;
  logic [NREG-1:0][CW-1:0] mem_cnt_q, mem_cnt_d;
  logic [NREG-1:0]         busy_d;

  // Ready depends only on stored occupancy: no pass-through when full.
  assign aluReady = !reset && (alu_count < FCW'(DEPTH));
  assign memReady = !reset && (mem_count < FCW'(DEPTH));

  // Zero-register writes may complete the handshake without being enqueued.
  assign alu_push = aluValid && aluReady && !(DROP_XZR && (aluAddr == AW'(REG_XZR)));
  assign mem_push = memValid && memReady && !(DROP_XZR && (memAddr == AW'(REG_XZR)));

  regfile_writeback_arbiter_fifo #(.W(EW), .DEPTH(DEPTH)) u_alu_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (alu_push),
    .push_data_i ({aluAddr, aluData}),
    .pop_i       (alu_grant),
    .head_c_o    (alu_head),
    .empty_o     (alu_empty),
    .count_o     (alu_count)
  );

  regfile_writeback_arbiter_fifo #(.W(EW), .DEPTH(DEPTH)) u_mem_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (mem_push),
    .push_data_i ({memAddr, memData}),
    .pop_i       (mem_grant),
    .head_c_o    (mem_head),
    .empty_o     (mem_empty),
    .count_o     (mem_count)
  );

  // Round-robin grant; the pointer only moves when both heads compete.
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    rr_d      = rr_q;
    if (!alu_empty && !mem_empty) begin
      if (rr_q == SRC_ALU) begin
        alu_grant = 1'b1;
        rr_d      = SRC_MEM;
      end else begin
        mem_grant = 1'b1;
        rr_d      = SRC_ALU;
      end
    end else if (!alu_empty) begin
      alu_grant = 1'b1;
    end else if (!mem_empty) begin
      mem_grant = 1'b1;
    end
  end

  // Per-source pending counts: +1 on enqueue, -1 when the write-port cycle ends.
  always_comb begin
    alu_cnt_d = alu_cnt_q;
    mem_cnt_d = mem_cnt_q;
    if (write && (wr_src_q == SRC_ALU)) alu_cnt_d[wrAddr] = alu_cnt_d[wrAddr] - CW'(1);
    if (write && (wr_src_q == SRC_MEM)) mem_cnt_d[wrAddr] = mem_cnt_d[wrAddr] - CW'(1);
    if (alu_push) alu_cnt_d[aluAddr] = alu_cnt_d[aluAddr] + CW'(1);
    if (mem_push) mem_cnt_d[memAddr] = mem_cnt_d[memAddr] + CW'(1);
  end

  for (genvar r = 0; r < NREG; r++) begin : g_busy
    assign busy_d[r] = (alu_cnt_d[r] != '0) || (mem_cnt_d[r] != '0);
  end

  // Hazard: new write hits a register still outstanding on the other source,
  // including both sources enqueueing the same register in one cycle.
  always_comb begin
    conflict_d = 1'b0;
    if (alu_push && ((mem_cnt_q[aluAddr] != '0) || (mem_push && (memAddr == aluAddr))))
      conflict_d = 1'b1;
    if (mem_push && (alu_cnt_q[memAddr] != '0))
      conflict_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q      <= SRC_ALU;
      wr_src_q  <= SRC_ALU;
      write     <= 1'b0;
      wrAddr    <= '0;
      wrData    <= '0;
      conflict  <= 1'b0;
      busy      <= '0;
      alu_cnt_q <= '0;
      mem_cnt_q <= '0;
    end else begin
      rr_q      <= rr_d;
      write     <= alu_grant || mem_grant;
      conflict  <= conflict_d;
      busy      <= busy_d;
      alu_cnt_q <= alu_cnt_d;
      mem_cnt_q <= mem_cnt_d;
      if (alu_grant) begin
        {wrAddr, wrData} <= alu_head;
        wr_src_q         <= SRC_ALU;
      end else if (mem_grant) begin
        {wrAddr, wrData} <= mem_head;
        wr_src_q         <= SRC_MEM;
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Randomised scoreboard bench for regfile_writeback_arbiter, with a
// queue-based reference model and a second instance built with DROP_XZR=1.
module tb_regfile_writeback_arbiter;

  localparam int DEPTH = 2;

  typedef struct {
    logic [4:0]  a;
    logic [63:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        aluValid, memValid;
  logic [4:0]  aluAddr, memAddr;
  logic [63:0] aluData, memData;
  logic        aluReady, memReady, write, conflict;
  logic [4:0]  wrAddr;
  logic [63:0] wrData;
  logic [31:0] busy;

  logic        d_aluValid, d_memValid;
  logic [4:0]  d_aluAddr, d_memAddr;
  logic [63:0] d_aluData, d_memData;
  logic        d_aluReady, d_memReady, d_write, d_conflict;
  logic [4:0]  d_wrAddr;
  logic [63:0] d_wrData;
  logic [31:0] d_busy;

  always #5 clk = ~clk;

  regfile_writeback_arbiter #(.DEPTH(DEPTH), .DROP_XZR(1'b0)) dut (
    .clk(clk), .reset(reset),
    .aluValid(aluValid), .aluReady(aluReady), .aluAddr(aluAddr), .aluData(aluData),
    .memValid(memValid), .memReady(memReady), .memAddr(memAddr), .memData(memData),
    .write(write), .wrAddr(wrAddr), .wrData(wrData), .busy(busy), .conflict(conflict)
  );

  regfile_writeback_arbiter #(.DEPTH(DEPTH), .DROP_XZR(1'b1)) dut_drop (
    .clk(clk), .reset(reset),
    .aluValid(d_aluValid), .aluReady(d_aluReady), .aluAddr(d_aluAddr), .aluData(d_aluData),
    .memValid(d_memValid), .memReady(d_memReady), .memAddr(d_memAddr), .memData(d_memData),
    .write(d_write), .wrAddr(d_wrAddr), .wrData(d_wrData), .busy(d_busy), .conflict(d_conflict)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  ent_t        qa[$], qm[$];
  ent_t        exp_w[$];
  int          cnt_a[32], cnt_m[32];
  logic        m_write, m_src, m_rr, m_conf;
  logic [4:0]  m_addr;
  bit          pa, pm, took;
  ent_t        g;

  always @(posedge clk or posedge reset) begin : model
    if (reset) begin
      qa.delete();
      qm.delete();
      m_write = 1'b0; m_addr = '0; m_src = 1'b0; m_rr = 1'b0; m_conf = 1'b0;
      for (int r = 0; r < 32; r++) begin cnt_a[r] = 0; cnt_m[r] = 0; end
    end else begin
      pa = aluValid && (qa.size() < DEPTH);
      pm = memValid && (qm.size() < DEPTH);
      m_conf = (pa && (cnt_m[aluAddr] > 0 || (pm && memAddr == aluAddr))) ||
               (pm && cnt_a[memAddr] > 0);
      if (m_write) begin
        if (m_src) cnt_m[m_addr]--; else cnt_a[m_addr]--;
      end
      took = 1'b0;
      if (qa.size() > 0 && (qm.size() == 0 || m_rr == 1'b0)) begin
        g = qa.pop_front(); m_src = 1'b0; took = 1'b1;
        if (qm.size() > 0) m_rr = 1'b1;
      end else if (qm.size() > 0) begin
        g = qm.pop_front(); m_src = 1'b1; took = 1'b1;
        if (qa.size() > 0) m_rr = 1'b0;
      end
      m_write = took;
      if (took) begin
        m_addr = g.a;
        exp_w.push_back(g);
      end
      if (pa) begin qa.push_back('{aluAddr, aluData}); cnt_a[aluAddr]++; end
      if (pm) begin qm.push_back('{memAddr, memData}); cnt_m[memAddr]++; end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int          rd_idx = 0;
  bit          end_req = 1'b0, end_done = 1'b0;
  logic [31:0] busy_exp;
  ent_t        e;

  always @(negedge clk) begin : monitor
    if (reset) rd_idx = exp_w.size();
    check("write", 64'(write), 64'(m_write));
    if (write === 1'b1) begin
      if (rd_idx >= exp_w.size()) begin
        check("unexpected_write", 64'(1), 64'(0));
      end else begin
        e = exp_w[rd_idx];
        rd_idx++;
        check("wrAddr", 64'(wrAddr), 64'(e.a));
        check("wrData", wrData, e.d);
      end
    end
    check("aluReady", 64'(aluReady), 64'(!reset && qa.size() < DEPTH));
    check("memReady", 64'(memReady), 64'(!reset && qm.size() < DEPTH));
    for (int r = 0; r < 32; r++) busy_exp[r] = (cnt_a[r] + cnt_m[r]) > 0;
    check("busy", 64'(busy), 64'(busy_exp));
    check("conflict", 64'(conflict), 64'(m_conf));
    // Zero-register writes on the DROP_XZR build never reach the port.
    check("drop_write", 64'(d_write), 64'(0));
    check("drop_busy", 64'(d_busy), 64'(0));
    check("drop_conflict", 64'(d_conflict), 64'(0));
    check("drop_aluReady", 64'(d_aluReady), 64'(!reset));
    check("drop_memReady", 64'(d_memReady), 64'(!reset));
    if (end_req && !end_done) begin
      check("all_writes_seen", 64'(rd_idx), 64'(exp_w.size()));
      end_done = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic av, input logic [4:0] aa, input logic [63:0] ad,
                      input logic mv, input logic [4:0] ma, input logic [63:0] md);
    aluValid = av; aluAddr = aa; aluData = ad;
    memValid = mv; memAddr = ma; memData = md;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
  endtask

  function automatic logic [63:0] rnd64();
    return {32'($urandom), 32'($urandom)};
  endfunction

  initial begin : drop_stim
    d_aluValid = 1'b0; d_memValid = 1'b0;
    d_aluAddr = 5'd31; d_memAddr = 5'd31;
    d_aluData = '0; d_memData = '0;
    forever begin
      @(posedge clk);
      #2;
      d_aluValid = 1'($urandom);
      d_memValid = 1'($urandom);
      d_aluData  = rnd64();
      d_memData  = rnd64();
    end
  end

  initial begin : main_stim
    reset = 1'b1;
    aluValid = 1'b0; memValid = 1'b0;
    aluAddr = '0; memAddr = '0; aluData = '0; memData = '0;
    // Reset held with a valid ALU request: nothing accepted.
    for (int i = 0; i < 5; i++) step(1'b1, 5'd3, 64'h1234, 1'b0, 5'd0, 64'd0);
    aluValid = 1'b0;
    reset = 1'b0;
    idle(3);

    // Single ALU write.
    step(1'b1, 5'd8, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 5'd0, 64'd0);
    idle(5);

    // Contention on both sources every cycle.
    for (int i = 0; i < 6; i++)
      step(1'b1, 5'd15, 64'hCCCC_CCCC_CCCC_CC00 + 64'(i),
           1'b1, 5'd31, 64'hF0F0_F0F0_F0F0_F000 + 64'(i));
    idle(8);

    // Memory backpressure while the ALU floods.
    for (int i = 0; i < 8; i++)
      step(1'b1, 5'($urandom_range(16, 30)), rnd64(), 1'b1, 5'd5, 64'h100 + 64'(i));
    idle(8);

    // Same register from both sources.
    step(1'b1, 5'd0, 64'hD1, 1'b0, 5'd0, 64'd0);
    step(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'hD2);
    idle(6);

    // Random traffic over a small register window to provoke hazards.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), rnd64(),
           1'($urandom_range(0, 9) < 5), 5'($urandom_range(0, 7)), rnd64());
    idle(8);

    // Reset in the middle of buffered traffic.
    for (int i = 0; i < 3; i++)
      step(1'b1, 5'd9, 64'h900 + 64'(i), 1'b1, 5'd10, 64'hA00 + 64'(i));
    aluValid = 1'b0; memValid = 1'b0;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(10);

    // Short random burst after recovery, then drain.
    for (int i = 0; i < 40; i++)
      step(1'($urandom), 5'($urandom), rnd64(), 1'($urandom), 5'($urandom), rnd64());
    idle(12);

    end_req = 1'b1;
    for (int i = 0; i < 4 && !end_done; i++) @(posedge clk);
    if (!end_done) begin
      errors++;
      checks++;
      $display("FAIL end_of_run: final check not reached");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
